// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for a 4-stage in-order pipeline: load-use bubbles, redirect flushes, memory wait with timeout.
// Stall/flush outputs are combinational from state and inputs (zero latency); a memory wait holds every stage until ack.
module pipeline_ctrl #(
    parameter int LOAD_BUBBLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_d_rs1,
    input  logic [4:0]       i_d_rs2,
    input  logic             i_d_uses_rs1,
    input  logic             i_d_uses_rs2,
    input  logic [4:0]       i_e_rd,
    input  logic             i_e_is_load,
    input  logic [1:0]       i_e_pc_sel,
    input  logic             i_m_req,
    input  logic             i_m_ack,
    output logic             o_f_stall,
    output logic             o_d_stall,
    output logic             o_e_stall,
    output logic             o_m_stall,
    output logic             o_d_flush,
    output logic             o_e_flush,
    output logic             o_err,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    localparam int                WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 2);
    localparam logic [1:0]        BUB_INIT  = 2'(LOAD_BUBBLES - 1);

    state_t            r_state;
    state_t            r_ret;
    logic [1:0]        r_bub;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_stall_cnt;

    state_t            w_state_nxt;
    state_t            w_ret_nxt;
    logic [1:0]        w_bub_nxt;
    logic [WAIT_W-1:0] w_wait_nxt;

    logic w_mw;
    logic w_redir;
    logic w_haz;
    logic w_f_stall;
    logic w_d_stall;
    logic w_e_stall;
    logic w_m_stall;
    logic w_d_flush;
    logic w_e_flush;

    assign w_mw    = i_m_req & ~i_m_ack;
    assign w_redir = (i_e_pc_sel != 2'd0);
    assign w_haz   = i_e_is_load & (i_e_rd != 5'd0) &
                     ((i_d_uses_rs1 & (i_d_rs1 == i_e_rd)) |
                      (i_d_uses_rs2 & (i_d_rs2 == i_e_rd)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_RUN;
            r_ret       <= ST_RUN;
            r_bub       <= 2'd0;
            r_wait      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
            r_bub   <= w_bub_nxt;
            r_wait  <= w_wait_nxt;
            if (w_f_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // The wait counter restarts on every entry so a wait taken from LU_STALL gets the full timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_bub_nxt   = r_bub;
        w_wait_nxt  = r_wait;
        case (r_state)
            ST_RUN: begin
                if (w_mw) begin
                    w_state_nxt = ST_MEM_WAIT;
                    w_ret_nxt   = ST_RUN;
                    w_wait_nxt  = '0;
                end else if (!w_redir && w_haz && (LOAD_BUBBLES > 1)) begin
                    w_state_nxt = ST_LU_STALL;
                    w_bub_nxt   = BUB_INIT;
                end
            end
            ST_LU_STALL: begin
                if (w_mw) begin
                    w_state_nxt = ST_MEM_WAIT;
                    w_ret_nxt   = ST_LU_STALL;
                    w_wait_nxt  = '0;
                end else begin
                    w_bub_nxt = r_bub - 2'd1;
                    if (r_bub == 2'd1) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (i_m_ack) begin
                    w_state_nxt = r_ret;
                end else begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                    if (r_wait == WAIT_LAST) begin
                        w_state_nxt = ST_ERROR;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_ERROR;
            end
        endcase
    end

    always_comb begin
        w_f_stall = 1'b0;
        w_d_stall = 1'b0;
        w_e_stall = 1'b0;
        w_m_stall = 1'b0;
        w_d_flush = 1'b0;
        w_e_flush = 1'b0;
        if (i_rst) begin
            w_d_flush = 1'b1;
            w_e_flush = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mw) begin
                        w_f_stall = 1'b1;
                        w_d_stall = 1'b1;
                        w_e_stall = 1'b1;
                        w_m_stall = 1'b1;
                    end else if (w_redir) begin
                        w_d_flush = 1'b1;
                        w_e_flush = 1'b1;
                    end else if (w_haz) begin
                        w_f_stall = 1'b1;
                        w_d_stall = 1'b1;
                        w_e_flush = 1'b1;
                    end
                end
                ST_LU_STALL: begin
                    w_f_stall = 1'b1;
                    w_d_stall = 1'b1;
                    if (w_mw) begin
                        w_e_stall = 1'b1;
                        w_m_stall = 1'b1;
                    end else begin
                        w_e_flush = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    w_f_stall = ~i_m_ack;
                    w_d_stall = ~i_m_ack;
                    w_e_stall = ~i_m_ack;
                    w_m_stall = ~i_m_ack;
                end
                default: begin
                    w_f_stall = 1'b1;
                    w_d_stall = 1'b1;
                    w_e_stall = 1'b1;
                    w_m_stall = 1'b1;
                end
            endcase
        end
    end

    assign o_f_stall   = w_f_stall;
    assign o_d_stall   = w_d_stall;
    assign o_e_stall   = w_e_stall;
    assign o_m_stall   = w_m_stall;
    assign o_d_flush   = w_d_flush;
    assign o_e_flush   = w_e_flush;
    assign o_err       = (r_state == ST_ERROR);
    assign o_state     = r_state;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Three differently parameterised controllers share one stimulus stream; a reference model queues expectations, a monitor checks.
module tb_pipeline_ctrl;

    localparam int NI = 3;
    localparam int OW = 25;
    typedef logic [NI*OW-1:0] exp_t;

    int P_LB [NI] = '{1, 3, 2};
    int P_MT [NI] = '{8, 8, 4};
    int P_CW [NI] = '{4, 4, 16};

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] d_rs1, d_rs2, e_rd;
    logic       d_u1, d_u2, e_ld, m_req, m_ack;
    logic [1:0] e_pc_sel;

    logic       f_stall [NI];
    logic       d_stall [NI];
    logic       e_stall [NI];
    logic       m_stall [NI];
    logic       d_flush [NI];
    logic       e_flush [NI];
    logic       err     [NI];
    logic [1:0] st      [NI];
    logic [3:0]  cnt0;
    logic [3:0]  cnt1;
    logic [15:0] cnt2;

    int m_bub  [NI];
    int m_mcnt [NI];
    int m_cnt  [NI];
    bit m_wait [NI];
    bit m_err  [NI];

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(8), .CNT_W(4)) u0 (
        .i_clk(clk), .i_rst(rst), .i_d_rs1(d_rs1), .i_d_rs2(d_rs2),
        .i_d_uses_rs1(d_u1), .i_d_uses_rs2(d_u2), .i_e_rd(e_rd), .i_e_is_load(e_ld),
        .i_e_pc_sel(e_pc_sel), .i_m_req(m_req), .i_m_ack(m_ack),
        .o_f_stall(f_stall[0]), .o_d_stall(d_stall[0]), .o_e_stall(e_stall[0]), .o_m_stall(m_stall[0]),
        .o_d_flush(d_flush[0]), .o_e_flush(e_flush[0]), .o_err(err[0]), .o_state(st[0]), .o_stall_cnt(cnt0));

    pipeline_ctrl #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(8), .CNT_W(4)) u1 (
        .i_clk(clk), .i_rst(rst), .i_d_rs1(d_rs1), .i_d_rs2(d_rs2),
        .i_d_uses_rs1(d_u1), .i_d_uses_rs2(d_u2), .i_e_rd(e_rd), .i_e_is_load(e_ld),
        .i_e_pc_sel(e_pc_sel), .i_m_req(m_req), .i_m_ack(m_ack),
        .o_f_stall(f_stall[1]), .o_d_stall(d_stall[1]), .o_e_stall(e_stall[1]), .o_m_stall(m_stall[1]),
        .o_d_flush(d_flush[1]), .o_e_flush(e_flush[1]), .o_err(err[1]), .o_state(st[1]), .o_stall_cnt(cnt1));

    pipeline_ctrl #(.LOAD_BUBBLES(2), .MEM_TIMEOUT(4), .CNT_W(16)) u2 (
        .i_clk(clk), .i_rst(rst), .i_d_rs1(d_rs1), .i_d_rs2(d_rs2),
        .i_d_uses_rs1(d_u1), .i_d_uses_rs2(d_u2), .i_e_rd(e_rd), .i_e_is_load(e_ld),
        .i_e_pc_sel(e_pc_sel), .i_m_req(m_req), .i_m_ack(m_ack),
        .o_f_stall(f_stall[2]), .o_d_stall(d_stall[2]), .o_e_stall(e_stall[2]), .o_m_stall(m_stall[2]),
        .o_d_flush(d_flush[2]), .o_e_flush(e_flush[2]), .o_err(err[2]), .o_state(st[2]), .o_stall_cnt(cnt2));

    // Model: pending bubbles, an outstanding memory wait with its stall-cycle age, and a sticky error flag.
    task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd, input logic ld,
                        input logic [1:0] pcsel, input logic req, input logic ack);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; d_rs1 = rs1; d_rs2 = rs2; d_u1 = u1; d_u2 = u2;
        e_rd = rd; e_ld = ld; e_pc_sel = pcsel; m_req = req; m_ack = ack;
        e = '0;
        for (int k = 0; k < NI; k++) begin
            logic f, dd, ee, mm, df, ef;
            logic [1:0] s;
            logic [15:0] c;
            bit mw, redir, haz;
            mw    = req && !ack;
            redir = (pcsel != 0);
            haz   = ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
            s  = m_err[k] ? 2'd3 : m_wait[k] ? 2'd2 : (m_bub[k] > 0) ? 2'd1 : 2'd0;
            c  = 16'(m_cnt[k]);
            f = 0; dd = 0; ee = 0; mm = 0; df = 0; ef = 0;
            if (r) begin
                df = 1; ef = 1;
            end else if (m_err[k]) begin
                f = 1; dd = 1; ee = 1; mm = 1;
            end else if (m_wait[k]) begin
                f = !ack; dd = !ack; ee = !ack; mm = !ack;
            end else if (mw) begin
                f = 1; dd = 1; ee = 1; mm = 1;
            end else if (m_bub[k] > 0 || (!redir && haz)) begin
                f = 1; dd = 1; ef = 1;
            end else if (redir) begin
                df = 1; ef = 1;
            end
            e[k*OW +: OW] = {f, dd, ee, mm, df, ef, m_err[k], s, c};
            if (r) begin
                m_bub[k] = 0; m_mcnt[k] = 0; m_cnt[k] = 0; m_wait[k] = 0; m_err[k] = 0;
            end else begin
                if (f && m_cnt[k] < (1 << P_CW[k]) - 1) m_cnt[k]++;
                if (m_err[k]) begin
                end else if (m_wait[k]) begin
                    if (ack) m_wait[k] = 0;
                    else begin
                        m_mcnt[k]++;
                        if (m_mcnt[k] == P_MT[k]) begin m_err[k] = 1; m_wait[k] = 0; end
                    end
                end else if (mw) begin
                    m_wait[k] = 1; m_mcnt[k] = 1;
                end else if (m_bub[k] > 0) begin
                    m_bub[k]--;
                end else if (!redir && haz) begin
                    m_bub[k] = P_LB[k] - 1;
                end
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic hazard();
        step(0, 5, 0, 1, 0, 5, 1, 0, 0, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp_t x;
                x = sb_q.pop_front();
                for (int k = 0; k < NI; k++) begin
                    logic [OW-1:0] a, w;
                    logic [15:0] c;
                    c = (k == 0) ? {12'd0, cnt0} : (k == 1) ? {12'd0, cnt1} : cnt2;
                    a = {f_stall[k], d_stall[k], e_stall[k], m_stall[k], d_flush[k], e_flush[k], err[k], st[k], c};
                    w = x[k*OW +: OW];
                    checks++;
                    if (a !== w) begin
                        failures++;
                        $display("FAIL outputs u%0d cycle %0d: got fdem=%b df/ef=%b err=%b st=%0d cnt=%0d, expected fdem=%b df/ef=%b err=%b st=%0d cnt=%0d",
                                 k, cyc, a[24:21], a[20:19], a[18], a[17:16], a[15:0],
                                 w[24:21], w[20:19], w[18], w[17:16], w[15:0]);
                    end
                end
                cyc++;
            end
        end
    end

    initial begin
        rst = 1; d_rs1 = 0; d_rs2 = 0; d_u1 = 0; d_u2 = 0;
        e_rd = 0; e_ld = 0; e_pc_sel = 0; m_req = 0; m_ack = 0;
        for (int k = 0; k < NI; k++) begin
            m_bub[k] = 0; m_mcnt[k] = 0; m_cnt[k] = 0; m_wait[k] = 0; m_err[k] = 0;
        end
        repeat (2) @(posedge clk);

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        hazard();
        idle(4);
        step(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 9, 0, 1, 9, 1, 0, 0, 0);
        idle(3);
        step(0, 5, 0, 0, 0, 5, 1, 0, 0, 0);
        step(0, 5, 0, 1, 0, 5, 1, 2'd1, 0, 0);
        step(0, 5, 0, 1, 0, 5, 1, 2'd3, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(2);
        hazard();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(4);
        repeat (12) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 5, 0, 1, 0, 5, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        repeat (20) hazard();
        idle(3);
        hazard();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            logic [1:0] ps;
            ps = ($urandom_range(0, 7) < 2) ? 2'($urandom_range(1, 3)) : 2'd0;
            step(($urandom_range(0, 59) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ps,
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 4));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
